// File: rtl/pwm_multichannel_if.sv
// Register-write port for pwm_multichannel: one strobe, a 4-bit address and CW-bit data.
// The master drives the write; the slave (the PWM block) samples it on clk.
interface pwm_multichannel_if #(
    parameter int CW = 16
);
    logic          wr_en;
    logic [3:0]    wr_addr;
    logic [CW-1:0] wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/pwm_multichannel.sv
// Multi-channel PWM: one shared period counter and NCH comparators. Edge and center aligned.
// Period and duty writes land in shadow registers and reach the active set only at a period boundary.
module pwm_multichannel #(
    parameter int               CW         = 16,
    parameter int               NCH        = 4,
    parameter logic [NCH-1:0]   POLARITY   = {NCH{1'b0}},
    parameter int               RST_PERIOD = 99
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                center,
    pwm_multichannel_if.slave   bus,
    output logic [NCH-1:0]      pwm,
    output logic                period_tick
);

    localparam logic [CW-1:0] ONE = CW'(1);

    logic [CW-1:0]  cnt_reg, cnt_next;
    logic           dir_down_reg, dir_down_next;
    logic [CW-1:0]  period_sh_reg, period_act_reg;
    logic           mode_act_reg;
    logic           restart;
    logic [NCH-1:0] raw;
    logic [NCH-1:0] pwm_next;
    logic           tick_next;

    // restart marks every edge on which the counter begins a new period; the active set reloads there.
    always_comb begin
        cnt_next      = cnt_reg;
        dir_down_next = dir_down_reg;
        restart       = 1'b0;
        if (!enable) begin
            cnt_next      = '0;
            dir_down_next = 1'b0;
            restart       = 1'b1;
        end else if (!mode_act_reg) begin
            if (cnt_reg >= period_act_reg) begin
                cnt_next = '0;
                restart  = 1'b1;
            end else begin
                cnt_next = cnt_reg + ONE;
            end
        end else if (!dir_down_reg && cnt_reg < period_act_reg) begin
            cnt_next = cnt_reg + ONE;
        end else if (cnt_reg <= ONE) begin
            // Covers the bottom of the down ramp and the top of ramps for period 0 or 1.
            cnt_next      = '0;
            dir_down_next = 1'b0;
            restart       = 1'b1;
        end else begin
            cnt_next      = cnt_reg - ONE;
            dir_down_next = 1'b1;
        end
    end

    always_comb begin
        pwm_next  = POLARITY;
        tick_next = 1'b0;
        if (enable) begin
            pwm_next  = raw ^ POLARITY;
            tick_next = (cnt_reg == '0) && !dir_down_reg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg        <= '0;
            dir_down_reg   <= 1'b0;
            period_sh_reg  <= CW'(RST_PERIOD);
            period_act_reg <= CW'(RST_PERIOD);
            mode_act_reg   <= 1'b0;
            pwm            <= POLARITY;
            period_tick    <= 1'b0;
        end else begin
            cnt_reg      <= cnt_next;
            dir_down_reg <= dir_down_next;
            pwm          <= pwm_next;
            period_tick  <= tick_next;
            if (restart) begin
                period_act_reg <= period_sh_reg;
                mode_act_reg   <= center;
            end
            if (bus.wr_en && bus.wr_addr == 4'd0) begin
                period_sh_reg <= bus.wr_data;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [CW-1:0] duty_sh_reg;
            logic [CW-1:0] duty_act_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    duty_sh_reg  <= '0;
                    duty_act_reg <= '0;
                end else begin
                    if (restart) begin
                        duty_act_reg <= duty_sh_reg;
                    end
                    if (bus.wr_en && bus.wr_addr == 4'(gi + 1)) begin
                        duty_sh_reg <= bus.wr_data;
                    end
                end
            end

            assign raw[gi] = (cnt_reg < duty_act_reg);
        end
    endgenerate

endmodule

// File: tb/tb_pwm_multichannel.sv
// Self-checking bench for pwm_multichannel: a table of period/duty/mode vectors with expected
// period length and per-channel high counts, plus directed sequences for the multi-cycle corners.
module tb_pwm_multichannel;

    localparam int          CW  = 16;
    localparam int          NCH = 4;
    localparam logic [3:0]  POL = 4'b0010;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       center;
    logic [3:0] pwm;
    logic       period_tick;

    int checks   = 0;
    int failures = 0;

    pwm_multichannel_if #(.CW(CW)) bus ();

    pwm_multichannel #(
        .CW(CW), .NCH(NCH), .POLARITY(POL), .RST_PERIOD(99)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .center(center),
        .bus(bus), .pwm(pwm), .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   period;
        int   duty [4];
        logic ctr;
        int   len;
        int   high [4];
    } vec_t;

    vec_t vecs [5];

    task automatic tk();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wr(input int addr, input int data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'(addr);
        bus.wr_data = CW'(data);
        tk();
        bus.wr_en   = 1'b0;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   hi [4];
        int   extra;
        logic [3:0] r;
        v = vecs[idx];
        enable = 1'b0;
        center = v.ctr;
        wr(0, v.period);
        for (int c = 0; c < 4; c++) wr(c + 1, v.duty[c]);
        wr(5, 0);
        wr(15, 3);
        tk();
        chk($sformatf("v%0d_idle_pwm", idx), int'(pwm), int'(POL));
        chk($sformatf("v%0d_idle_tick", idx), int'(period_tick), 0);
        enable = 1'b1;
        tk();
        chk($sformatf("v%0d_tick_first", idx), int'(period_tick), 1);
        extra = 0;
        for (int c = 0; c < 4; c++) hi[c] = 0;
        for (int s = 0; s < v.len; s++) begin
            if (s > 0 && period_tick) extra++;
            r = pwm ^ POL;
            for (int c = 0; c < 4; c++) if (r[c]) hi[c]++;
            tk();
        end
        chk($sformatf("v%0d_tick_next", idx), int'(period_tick), 1);
        chk($sformatf("v%0d_extra_ticks", idx), extra, 0);
        for (int c = 0; c < 4; c++)
            chk($sformatf("v%0d_high_ch%0d", idx, c), hi[c], v.high[c]);
        $display("vec %0d: period=%0d center=%0d len=%0d high=%0d/%0d/%0d/%0d",
                 idx, v.period, v.ctr, v.len, hi[0], hi[1], hi[2], hi[3]);
        enable = 1'b0;
    endtask

    // Edge mode period 9, ch0 duty 2; duty 7 is written at sample 'at'.
    task automatic run_write(input int at, input int e0, input int e1, input int e2, input string nm);
        int h [3];
        int tick_bad;
        enable = 1'b0;
        center = 1'b0;
        wr(0, 9);
        wr(1, 2);
        tk();
        enable = 1'b1;
        tk();
        tick_bad = 0;
        for (int p = 0; p < 3; p++) h[p] = 0;
        for (int s = 0; s < 30; s++) begin
            if ((s % 10 == 0) != period_tick) tick_bad++;
            if (pwm[0] ^ POL[0]) h[s / 10]++;
            if (s == at) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = 4'd1;
                bus.wr_data = CW'(7);
            end
            if (s == at + 1) bus.wr_en = 1'b0;
            tk();
        end
        chk({nm, "_ticks"}, tick_bad, 0);
        chk({nm, "_p0"}, h[0], e0);
        chk({nm, "_p1"}, h[1], e1);
        chk({nm, "_p2"}, h[2], e2);
        $display("%s: write at sample %0d, ch0 high per period %0d/%0d/%0d", nm, at, h[0], h[1], h[2]);
        enable = 1'b0;
    endtask

    initial begin
        vec_t v;
        int   bad_tick;
        int   bad_raw;
        int   n;
        int   nz;
        logic exp_t;

        v = '{period: 9, duty: '{0, 3, 10, 5}, ctr: 1'b0, len: 10, high: '{0, 3, 10, 5}};
        vecs[0] = v;
        v = '{period: 8, duty: '{3, 0, 9, 8},  ctr: 1'b1, len: 16, high: '{5, 0, 16, 15}};
        vecs[1] = v;
        v = '{period: 4, duty: '{1, 4, 5, 6},  ctr: 1'b0, len: 5,  high: '{1, 4, 5, 5}};
        vecs[2] = v;
        v = '{period: 1, duty: '{1, 2, 0, 1},  ctr: 1'b1, len: 2,  high: '{1, 2, 0, 1}};
        vecs[3] = v;
        v = '{period: 3, duty: '{2, 3, 4, 1},  ctr: 1'b1, len: 6,  high: '{3, 5, 6, 1}};
        vecs[4] = v;

        reset       = 1'b1;
        enable      = 1'b0;
        center      = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = 4'd0;
        bus.wr_data = '0;
        repeat (3) tk();
        chk("reset_pwm", int'(pwm), int'(POL));
        chk("reset_tick", int'(period_tick), 0);
        reset = 1'b0;
        bad_tick = 0;
        for (int s = 0; s < 5; s++) begin
            tk();
            if (pwm != POL || period_tick) bad_tick++;
        end
        chk("idle_after_release", bad_tick, 0);
        $display("reset: pwm=%b tick=%0d", pwm, period_tick);

        for (int i = 0; i < 5; i++) run_vec(i);

        run_write(3, 2, 7, 7, "wr_mid");
        run_write(8, 2, 2, 7, "wr_boundary");

        // Period 0: every cycle is a boundary; period 4 written at sample 5 shows up as a 5-cycle period.
        enable = 1'b0;
        center = 1'b0;
        wr(0, 0);
        wr(1, 1);
        tk();
        enable = 1'b1;
        tk();
        bad_tick = 0;
        bad_raw  = 0;
        for (int s = 0; s < 19; s++) begin
            exp_t = (s <= 8) || (s == 13) || (s == 18);
            if (period_tick != exp_t) bad_tick++;
            if ((pwm[0] ^ POL[0]) != exp_t) bad_raw++;
            if (s == 5) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = 4'd0;
                bus.wr_data = CW'(4);
            end
            if (s == 6) bus.wr_en = 1'b0;
            tk();
        end
        chk("p0_tick_pattern", bad_tick, 0);
        chk("p0_ch0_pattern", bad_raw, 0);
        $display("period0: tick errors=%0d ch0 errors=%0d", bad_tick, bad_raw);

        // Asynchronous reset mid-period, then RST_PERIOD and zero duties after release.
        enable = 1'b0;
        wr(0, 20);
        for (int c = 0; c < 4; c++) wr(c + 1, 10);
        tk();
        enable = 1'b1;
        repeat (7) tk();
        chk("pre_reset_pwm", int'(pwm), int'(4'b1111 ^ POL));
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_pwm", int'(pwm), int'(POL));
        chk("async_reset_tick", int'(period_tick), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tk();
        chk("post_reset_tick_first", int'(period_tick), 1);
        n  = 0;
        nz = 0;
        do begin
            if ((pwm ^ POL) != 4'b0000) nz++;
            tk();
            n++;
        end while (!period_tick && n < 300);
        chk("post_reset_period_len", n, 100);
        chk("post_reset_duty_zero", nz, 0);
        $display("post-reset: period length=%0d nonzero cycles=%0d", n, nz);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
